// File: rtl/serdes_rx_aligner_if.sv
// serdes_rx_aligner_if: receive-word and alignment-status bundle between SERDES fabric glue (master) and the aligner (slave).
interface serdes_rx_aligner_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    logic                    i_pll_lock;
    logic                    i_align_start;
    logic                    i_training;
    logic [NUM_CH*WIDTH-1:0] i_q_in;
    logic [NUM_CH-1:0]       i_data_valid;
    logic [NUM_CH-1:0]       o_bitslip_adj;
    logic [NUM_CH-1:0]       o_ch_lock;
    logic [NUM_CH-1:0]       o_ch_error;
    logic                    o_all_locked;
    logic [NUM_CH*5-1:0]     o_slip_cnt;
    modport master (
        output i_pll_lock, i_align_start, i_training, i_q_in, i_data_valid,
        input  o_bitslip_adj, o_ch_lock, o_ch_error, o_all_locked, o_slip_cnt
    );
    modport slave (
        input  i_pll_lock, i_align_start, i_training, i_q_in, i_data_valid,
        output o_bitslip_adj, o_ch_lock, o_ch_error, o_all_locked, o_slip_cnt
    );
endinterface

// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner: per-channel autonomous bit-slip search for a training word, with lock/fail reporting.
// Define SERDES_RX_ALIGNER_RELOCK_EN to drop lock and re-search after LOSS_COUNT consecutive mismatches.
module serdes_rx_aligner #(
    parameter int         NUM_CH        = 4,
    parameter int         WIDTH         = 8,
    parameter logic [9:0] TRAIN_PATTERN = 10'h05C,
    parameter logic [3:0] SLIP_WAIT     = 4'd4,
    parameter logic [7:0] MATCH_COUNT   = 8'd8,
    parameter logic [4:0] MAX_SLIPS     = 5'(2 * WIDTH),
    parameter logic [7:0] LOSS_COUNT    = 8'd4
) (
    input logic                i_clk,
    input logic                i_rst,
    serdes_rx_aligner_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SLIP   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;
    localparam logic [WIDTH-1:0] PAT = TRAIN_PATTERN[WIDTH-1:0];
    logic [NUM_CH-1:0]   w_lock;
    logic [NUM_CH-1:0]   w_err;
    logic [NUM_CH-1:0]   w_adj;
    logic [NUM_CH*5-1:0] w_cnt;
    logic                r_all;
`ifndef SERDES_RX_ALIGNER_RELOCK_EN
    logic w_unused_loss;
    assign w_unused_loss = ^LOSS_COUNT;
`endif
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [2:0] r_state;
        logic [3:0] r_wait;
        logic [7:0] r_match;
        logic [4:0] r_slips;
        logic       w_valid;
        logic       w_hit;
        logic       w_drop;
        assign w_valid = bus.i_data_valid[c];
        assign w_hit   = bus.i_q_in[c*WIDTH +: WIDTH] == PAT;
`ifdef SERDES_RX_ALIGNER_RELOCK_EN
        logic [7:0] r_loss;
        assign w_drop = r_state == S_LOCKED && w_valid && bus.i_training && !w_hit && r_loss + 8'd1 == LOSS_COUNT;
        always_ff @(posedge i_clk) begin
            if (i_rst || (bus.i_pll_lock && bus.i_align_start) || w_drop)
                r_loss <= '0;
            else if (bus.i_pll_lock && r_state == S_LOCKED && w_valid && bus.i_training)
                r_loss <= w_hit ? '0 : r_loss + 8'd1;
        end
`else
        assign w_drop = 1'b0;
`endif
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state <= S_IDLE;
                r_wait  <= '0;
                r_match <= '0;
                r_slips <= '0;
            end else if (!bus.i_pll_lock) begin
                r_state <= S_IDLE;
            end else if (bus.i_align_start) begin
                r_state <= S_WAIT;
                r_wait  <= SLIP_WAIT;
                r_match <= '0;
                r_slips <= '0;
            end else begin
                case (r_state)
                    S_WAIT: if (w_valid) begin
                        r_wait <= r_wait - 4'd1;
                        if (r_wait == 4'd1) r_state <= S_CHECK;
                    end
                    S_CHECK: if (w_valid && bus.i_training) begin
                        r_match <= w_hit ? r_match + 8'd1 : '0;
                        if (w_hit && r_match + 8'd1 == MATCH_COUNT) r_state <= S_LOCKED;
                        else if (!w_hit && r_slips == MAX_SLIPS) r_state <= S_FAIL;
                        else if (!w_hit) begin
                            r_state <= S_SLIP;
                            r_slips <= r_slips + {4'd0, r_slips != 5'd31};
                        end
                    end
                    S_SLIP: begin
                        r_state <= S_WAIT;
                        r_wait  <= SLIP_WAIT;
                    end
                    S_LOCKED: if (w_drop) begin
                        r_state <= S_WAIT;
                        r_wait  <= SLIP_WAIT;
                        r_match <= '0;
                        r_slips <= '0;
                    end
                    default: ;
                endcase
            end
        end
        assign w_lock[c]         = r_state == S_LOCKED;
        assign w_err[c]          = r_state == S_FAIL;
        assign w_adj[c]          = r_state == S_SLIP;
        assign w_cnt[c*5 +: 5]   = r_slips;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_all <= 1'b0;
        else r_all <= &w_lock;
    end
    assign bus.o_bitslip_adj = w_adj;
    assign bus.o_ch_lock     = w_lock;
    assign bus.o_ch_error    = w_err;
    assign bus.o_all_locked  = r_all;
    assign bus.o_slip_cnt    = w_cnt;
endmodule

// File: doc/serdes_rx_aligner.md
Name: serdes_rx_aligner

Overview:
- Multi-channel word-alignment controller placed between I_SERDES receive channels and fabric logic.
- Watches each channel's deserialized word for a training pattern and pulses that channel's BITSLIP_ADJ until the pattern is seen for MATCH_COUNT consecutive valid words.
- Reports per-channel lock and failure, plus an aggregate all-locked flag.
- Generalises single-channel fixed-width SERDES handling to NUM_CH channels of WIDTH bits, with autonomous bit-slip search.

Parameters:
- NUM_CH, 4, number of receive channels (1-16)
- WIDTH, 8, deserialization width per channel (3-10)
- TRAIN_PATTERN, 8'h5C, expected aligned word; low WIDTH bits used
- SLIP_WAIT, 4, valid words discarded after reset/slip before comparing (1-15)
- MATCH_COUNT, 8, consecutive matching valid words required for lock (1-255)
- MAX_SLIPS, 2*WIDTH, slips attempted before declaring failure
- LOSS_COUNT, 4, consecutive mismatches in LOCKED that drop lock (used only with the optional feature)

Ports:
- CLK_IN  input  1  fabric clock; all logic on the rising edge
- RST  input  1  synchronous, active-high reset
- PLL_LOCK  input  1  PLL lock shared by all channels
- ALIGN_START  input  1  level-sampled request to (re)start alignment on all channels
- TRAINING  input  1  high while the far end transmits TRAIN_PATTERN
- Q_IN  input  NUM_CH*WIDTH  deserialized words; channel c at [c*WIDTH +: WIDTH]
- DATA_VALID  input  NUM_CH  per-channel word-valid strobe
- BITSLIP_ADJ  output  NUM_CH  one-cycle slip pulse per channel, to I_SERDES BITSLIP_ADJ
- CH_LOCK  output  NUM_CH  channel aligned
- CH_ERROR  output  NUM_CH  channel exhausted MAX_SLIPS without lock
- ALL_LOCKED  output  1  AND of CH_LOCK, registered
- SLIP_CNT  output  NUM_CH*5  slips issued per channel since last start

Behaviour:
- Reset values: RST=1 puts every channel in IDLE and clears all counters and outputs (BITSLIP_ADJ, CH_LOCK, CH_ERROR, ALL_LOCKED, SLIP_CNT = 0). RST has priority over all other inputs.
- Channels have independent FSMs: IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL.
- PLL_LOCK=0: every channel goes to IDLE on the next edge, from any state. CH_LOCK and CH_ERROR clear. SLIP_CNT holds.
- Start: in any state, ALIGN_START=1 with PLL_LOCK=1 sends the channel to WAIT on the next edge. wait_cnt loads SLIP_WAIT; match_cnt and SLIP_CNT clear; CH_LOCK and CH_ERROR clear. ALIGN_START is ignored while PLL_LOCK=0.
- WAIT: wait_cnt decrements only on DATA_VALID[c]=1. When the decrement reaches 0, go to CHECK. Words are never compared in WAIT.
- CHECK: compare only when DATA_VALID[c]=1 and TRAINING=1. Any other cycle holds state.
  - Match: match_cnt increments. On reaching MATCH_COUNT, go to LOCKED and set CH_LOCK on the same edge.
  - Mismatch: match_cnt clears. Go to FAIL if SLIP_CNT==MAX_SLIPS, otherwise go to SLIP.
- SLIP: BITSLIP_ADJ[c]=1 for exactly one cycle and SLIP_CNT increments (saturates at 31). Next state WAIT with wait_cnt=SLIP_WAIT. Two slips on one channel are always at least SLIP_WAIT+1 cycles apart.
- LOCKED: CH_LOCK=1. Exit only through start, PLL_LOCK loss, RST, or the optional feature.
- FAIL: CH_ERROR=1 and no further slips. Exit only through start, PLL_LOCK loss or RST.
- ALL_LOCKED is registered one cycle after the CH_LOCK vector becomes all-ones. It falls one cycle after any CH_LOCK falls.
- Simultaneous events: priority is RST, then PLL_LOCK=0, then ALIGN_START, then FSM progress. A match on the same cycle as ALIGN_START is discarded.
- Latency, best case (word already aligned, DATA_VALID every cycle): CH_LOCK rises SLIP_WAIT+MATCH_COUNT cycles after the start edge.

Optional Feature:
- Macro SERDES_RX_ALIGNER_RELOCK_EN.
- Defined: in LOCKED with TRAINING=1, each valid mismatch increments loss_cnt and each valid match clears it. On reaching LOSS_COUNT:
  - CH_LOCK clears;
  - SLIP_CNT clears;
  - the channel enters WAIT and a new search begins automatically.
- Not defined: LOCKED ignores data entirely. The loss_cnt logic and the LOSS_COUNT parameter have no effect.

Test Plan:
- Aligned start: NUM_CH=1, WIDTH=8, Q_IN=8'h5C every cycle, DATA_VALID=1, TRAINING=1, ALIGN_START pulse -> zero BITSLIP_ADJ pulses, CH_LOCK rises 12 cycles after start, ALL_LOCKED one cycle later.
- Slip search: model rotates the word by one bit per BITSLIP_ADJ pulse, initial offset 3 -> exactly 3 BITSLIP_ADJ pulses each at least 5 cycles apart, SLIP_CNT=3, then CH_LOCK=1.
- Failure: Q_IN constant 8'hFF -> 16 slips, then CH_ERROR=1, SLIP_CNT=16, no further pulses; ALIGN_START clears CH_ERROR and restarts.
- Multi-channel: NUM_CH=4 with offsets 0,1,5,7 -> per-channel SLIP_CNT 0,1,5,7; ALL_LOCKED rises only after the last channel locks.
- PLL loss and reset mid-search: drop PLL_LOCK during SLIP -> next cycle all IDLE, CH_LOCK=0. Assert RST during WAIT -> all outputs 0 next edge. ALIGN_START while PLL_LOCK=0 -> no effect.
- Relock (macro defined, LOSS_COUNT=4): after lock, inject 3 mismatches then 1 match -> stays locked; inject 4 consecutive mismatches -> CH_LOCK falls and slipping resumes.
